// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode encodings, control bundle type and opcode classification shared by the sequencer
package ctrl_pkg;

    localparam logic [4:0] OP_NOP          = 5'd0;
    localparam logic [4:0] OP_ADD          = 5'd1;
    localparam logic [4:0] OP_ADDI         = 5'd2;
    localparam logic [4:0] OP_SUB          = 5'd3;
    localparam logic [4:0] OP_MOV          = 5'd4;
    localparam logic [4:0] OP_MOVI         = 5'd5;
    localparam logic [4:0] OP_SHL          = 5'd6;
    localparam logic [4:0] OP_SHR          = 5'd7;
    localparam logic [4:0] OP_SHLI         = 5'd8;
    localparam logic [4:0] OP_SHRI         = 5'd9;
    localparam logic [4:0] OP_AND          = 5'd10;
    localparam logic [4:0] OP_OR           = 5'd11;
    localparam logic [4:0] OP_ROT_L        = 5'd12;
    localparam logic [4:0] OP_BIT_MASK     = 5'd13;
    localparam logic [4:0] OP_XOR_REG      = 5'd14;
    localparam logic [4:0] OP_XOR_ADD_REG  = 5'd15;
    localparam logic [4:0] OP_LOAD_BYTE    = 5'd16;
    localparam logic [4:0] OP_LOAD_TOP     = 5'd17;
    localparam logic [4:0] OP_LOAD_LOWER_H = 5'd18;
    localparam logic [4:0] OP_LOAD_UPPER_H = 5'd19;
    localparam logic [4:0] OP_STORE_BYTE   = 5'd20;
    localparam logic [4:0] OP_STORE_TOP    = 5'd21;
    localparam logic [4:0] OP_STORE_TOP_I  = 5'd22;
    localparam logic [4:0] OP_SWAP         = 5'd23;
    localparam logic [4:0] OP_BEQ          = 5'd24;
    localparam logic [4:0] OP_B            = 5'd25;
    localparam logic [4:0] OP_B_LOOKUP     = 5'd26;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_MEM_RD,
        CLS_MEM_WR,
        CLS_SWAP,
        CLS_BR
    } op_class_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_in2_sel;
        logic [1:0] imm_ctr;
        logic [1:0] imm_or_lut;
        logic       num_bits;
        logic       rxor;
        logic       regfile_dat_sel;
        logic       regfile_wr_sel;
    } ctrl_t;

    // Encodings are grouped by class, so classification is a chain of range checks
    function automatic op_class_e op_class(input logic [4:0] op);
        return (op == OP_NOP)          ? CLS_NOP    :
               (op <= OP_XOR_ADD_REG)  ? CLS_ALU    :
               (op <= OP_LOAD_UPPER_H) ? CLS_MEM_RD :
               (op <= OP_STORE_TOP_I)  ? CLS_MEM_WR :
               (op == OP_SWAP)         ? CLS_SWAP   :
               (op <= OP_B_LOOKUP)     ? CLS_BR     : CLS_NOP;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode to control bundle, class and illegal flag
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 5
) (
    input  logic [OP_W-1:0] opcode_i,
    output ctrl_t           ctrl_o,
    output op_class_e       cls_o,
    output logic            br_cond_o,
    output logic            illegal_o
);

    logic [4:0] op;
    logic       hi;
    logic       imm;

    assign op = opcode_i[4:0];
    assign hi = |(opcode_i >> 5);

    // Any opcode with a bit set above bit 4 decodes as an illegal no-op
    always_comb begin
        cls_o     = hi ? CLS_NOP : op_class(op);
        illegal_o = hi || (op > OP_B_LOOKUP);
        br_cond_o = !hi && (op == OP_BEQ);
        imm       = !hi && (op inside {OP_ADDI, OP_MOVI, OP_SHLI, OP_SHRI, OP_BIT_MASK});
        ctrl_o             = '0;
        ctrl_o.reg_write   = (cls_o == CLS_ALU) || (cls_o == CLS_SWAP);
        ctrl_o.mem_read    = cls_o == CLS_MEM_RD;
        ctrl_o.mem_write   = cls_o == CLS_MEM_WR;
        ctrl_o.alu_in2_sel = imm;
        ctrl_o.imm_ctr     = imm ? 2'b10 : 2'b00;
        ctrl_o.num_bits    = !hi && (op == OP_BIT_MASK);
        ctrl_o.rxor        = !hi && (op inside {OP_XOR_REG, OP_XOR_ADD_REG});
        ctrl_o.imm_or_lut  = (!hi && (op == OP_B_LOOKUP)) ? 2'b01 : 2'b00;
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: handshake-driven multi-cycle control FSM with memory wait timeout, SWAP phases and branch flush
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W     = 5,
    parameter int unsigned MEM_TMO  = 15,
    parameter int unsigned SWAP_CYC = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            instr_valid,
    input  logic [OP_W-1:0] opcode,
    output logic            instr_ready,
    input  logic            alu_branch,
    input  logic            mem_ready,
    output ctrl_t           ctrl,
    output logic            swap_phase,
    output logic            jump_en,
    output logic            flush,
    output logic            busy,
    output logic            illegal_op,
    output logic            mem_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_EXEC     = 3'd1;
    localparam logic [2:0] S_MEM_WAIT = 3'd2;
    localparam logic [2:0] S_SWAP2    = 3'd3;
    localparam logic [2:0] S_FLUSH    = 3'd4;
    localparam logic [7:0] TMO        = 8'(MEM_TMO);

    logic [2:0] state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    op_class_e  cls_q, cls_d;
    logic       cond_q, cond_d;
    logic       ill_q, ill_d;
    logic       mem_err_q, mem_err_d;
    logic [7:0] cnt_q, cnt_d;

    ctrl_t      dec_ctrl;
    op_class_e  dec_cls;
    logic       dec_cond;
    logic       dec_ill;

    logic       accept;
    logic       taken;
    logic       single;
    logic       load_done;
    logic       mem_tmo;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .opcode_i  (opcode),
        .ctrl_o    (dec_ctrl),
        .cls_o     (dec_cls),
        .br_cond_o (dec_cond),
        .illegal_o (dec_ill)
    );

    assign taken       = (state_q == S_EXEC) && (cls_q == CLS_BR) && (!cond_q || alu_branch);
    assign single      = (cls_q == CLS_ALU) || (cls_q == CLS_NOP) ||
                         ((cls_q == CLS_SWAP) && (SWAP_CYC == 1)) ||
                         ((cls_q == CLS_BR) && !taken);
    assign instr_ready = reset_n && ((state_q == S_IDLE) || ((state_q == S_EXEC) && single));
    assign accept      = instr_valid && instr_ready;
    assign load_done   = (state_q == S_MEM_WAIT) && mem_ready && (cls_q == CLS_MEM_RD);
    assign mem_tmo     = (state_q == S_MEM_WAIT) && !mem_ready && (cnt_q == TMO);

    // Next state: an accept always starts a new EXEC; otherwise each multi-cycle state runs out to IDLE
    always_comb begin
        state_d   = S_IDLE;
        ctrl_d    = '0;
        cls_d     = cls_q;
        cond_d    = cond_q;
        ill_d     = 1'b0;
        cnt_d     = 8'd0;
        mem_err_d = mem_err_q || mem_tmo;
        if (accept) begin
            state_d = S_EXEC;
            ctrl_d  = dec_ctrl;
            cls_d   = dec_cls;
            cond_d  = dec_cond;
            ill_d   = dec_ill;
        end else begin
            case (state_q)
                S_EXEC: begin
                    if ((cls_q == CLS_MEM_RD) || (cls_q == CLS_MEM_WR)) begin
                        state_d          = S_MEM_WAIT;
                        ctrl_d.mem_read  = ctrl_q.mem_read;
                        ctrl_d.mem_write = ctrl_q.mem_write;
                        cnt_d            = 8'd1;
                    end else if ((cls_q == CLS_SWAP) && (SWAP_CYC == 2)) begin
                        state_d               = S_SWAP2;
                        ctrl_d.reg_write      = 1'b1;
                        ctrl_d.regfile_wr_sel = 1'b1;
                    end else begin
                        state_d = taken ? S_FLUSH : S_IDLE;
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_ready && !mem_tmo) begin
                        state_d          = S_MEM_WAIT;
                        ctrl_d.mem_read  = ctrl_q.mem_read;
                        ctrl_d.mem_write = ctrl_q.mem_write;
                        cnt_d            = cnt_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered outputs, cleared immediately by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            cls_q     <= CLS_NOP;
            cond_q    <= 1'b0;
            ill_q     <= 1'b0;
            cnt_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            cls_q     <= cls_d;
            cond_q    <= cond_d;
            ill_q     <= ill_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Load completion writes the returned data in the same cycle memory reports ready
    always_comb begin
        ctrl                 = ctrl_q;
        ctrl.reg_write       = ctrl_q.reg_write || load_done;
        ctrl.regfile_dat_sel = ctrl_q.regfile_dat_sel || load_done;
    end

    assign swap_phase = state_q == S_SWAP2;
    assign jump_en    = taken;
    assign flush      = state_q == S_FLUSH;
    assign busy       = state_q != S_IDLE;
    assign illegal_op = ill_q;
    assign mem_err    = mem_err_q;

endmodule
